seg7_shift_out: RTL and testbench
=================================

# seg7_shift_out

Serial output stage for the clock display. It sits directly downstream of the `bcd_to_7seg` decoders. On each refresh request it snapshots the decoded segment patterns and decimal points of all digits. It then shifts them MSB-first into an external 74HC595-style shift-register chain and pulses the storage latch, so the whole display updates from three pins.

## Interface
- `NUM_DIGITS`, default 6: number of display digits, one 8-bit byte each.
- `CLK_DIV`, default 4: system clocks per serial-clock half period; legal range ≥1.
- `COMMON_ANODE`, default 0: when 1, every shifted bit is inverted for active-low segments.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  refresh request; sampled only while idle.
- `segments`  in  7*NUM_DIGITS  decoder outputs concatenated; digit i at [7i+6:7i], bit 6 = seg a … bit 0 = seg g.
- `dots`  in  NUM_DIGITS  decimal point per digit; bit i = digit i.
- `busy`  out  1  high from the cycle after acceptance until transfer completes.
- `done`  out  1  one-cycle pulse at completion.
- `serial_clk`  out  1  shift clock to external chain; external device samples on its rising edge.
- `serial_data`  out  1  serial data.
- `serial_latch`  out  1  storage-register latch pulse.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: `start`=1 loads a snapshot shift register. Per digit the byte is {dots[i], segments[7i+6:7i]}, inverted if COMMON_ANODE. It also clears the bit counter and the divider and moves to SHIFT_LO.
- `segments` and `dots` are ignored after the snapshot; changes mid-transfer have no effect.
- Shift order:
  - Digit NUM_DIGITS-1 first, digit 0 last.
  - Within a byte: dp, a, b, c, d, e, f, g.
  - Total 8*NUM_DIGITS bits.
- SHIFT_LO, CLK_DIV cycles: `serial_clk`=0, `serial_data`=current bit, stable for the whole phase. Then move to SHIFT_HI.
- SHIFT_HI, CLK_DIV cycles: `serial_clk`=1, `serial_data` unchanged. At the end, advance the bit:
  - More bits remain: go to SHIFT_LO.
  - Last bit: go to LATCH.
- LATCH, CLK_DIV cycles: `serial_clk`=0, `serial_data`=0, `serial_latch`=1. Then go to IDLE with `done`=1 for exactly that first IDLE cycle.
- `start` while busy: ignored, not queued.
- `start` during the `done` cycle: accepted, because the block is idle.
- Bit counter: width clog2(8*NUM_DIGITS+1). Divider: width clog2(CLK_DIV+1). Neither wraps within a transfer.

## Timing
- Reset values, also forced by `reset_n`=0 in any state: state IDLE, `serial_clk`=0, `serial_data`=0, `serial_latch`=0, `busy`=0, `done`=0, counters 0.
- Reset mid-transfer:
  - Outputs take reset values at the next edge.
  - `serial_latch` is not asserted, so the partial data in the external chain is never displayed.
  - `done` is not pulsed.
- `start` high in cycle 0 while idle:
  - `busy`=1 and the first bit on `serial_data` from cycle 1.
  - First `serial_clk` rise at cycle 1+CLK_DIV.
- Each bit takes 2*CLK_DIV cycles. The latch is high for CLK_DIV cycles, starting at cycle 1+16*CLK_DIV*NUM_DIGITS.
- `done`=1 and `busy`=0 at cycle 1+16*CLK_DIV*NUM_DIGITS+CLK_DIV. With the defaults this is cycle 389.
- `start` held high continuously: `busy` is low for exactly one cycle (the `done` cycle) between transfers.
- `serial_data` changes only while `serial_clk` is 0, never in the same cycle as a rising edge.

## Test plan
- Reset: hold `reset_n`=0 for 5 cycles with `start`=1 → all outputs 0 throughout; no transfer starts until `reset_n`=1.
- Default transfer, digit i segments = 7'b0110000 (digit 1 pattern), `dots`=6'b000001 → bench samples `serial_data` on 48 `serial_clk` rises:
  - Five bytes 8'b00110000, then the last byte 8'b10110000.
  - `serial_latch` high for 4 cycles.
  - `done` in cycle 389 only.
- Mid-transfer activity: pulse `start` again and flip all `segments` at cycle 100 → captured 48 bits identical to the snapshot; a single `done` pulse.
- Reset at the 20th `serial_clk` rise → outputs 0 next cycle, no latch pulse, no `done`. A new `start` then gives a full, correct 48-bit transfer.
- COMMON_ANODE=1 with all-zero inputs → 48 captured ones; latch and `done` timing unchanged.
- `start` held high, CLK_DIV=1, NUM_DIGITS=2 → per transfer:
  - Bits on cycles 1–32, latch on cycle 33, `done` on cycle 34.
  - `busy` low exactly one cycle between transfers.

Source files
------------

// File: rtl/seg7_shift_out.sv
`default_nettype none
// ============================================================================
// Module   : seg7_shift_out
// Purpose  : Snapshots the decoded 7-segment patterns and decimal points of
//            all display digits and shifts them MSB-first into an external
//            74HC595-style chain, then pulses the storage latch.
// Revision : 1.0  initial release
// ============================================================================
module seg7_shift_out #(
  parameter int NUM_DIGITS   = 6,
  parameter int CLK_DIV      = 4,
  parameter int COMMON_ANODE = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [7*NUM_DIGITS-1:0] segments,
  input  logic [NUM_DIGITS-1:0]   dots,
  output logic                    busy,
  output logic                    done,
  output logic                    serial_clk,
  output logic                    serial_data,
  output logic                    serial_latch
);

  localparam int NBITS = 8 * NUM_DIGITS;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NBITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [NBITS-1:0]   snapshot;
  logic [NBITS-1:0]   shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               done_q;
  logic               phase_end;

  // Digit N-1 lands in the top byte so it leaves the chain first; dp is the
  // byte MSB, followed by a..g.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_snap
    if (COMMON_ANODE != 0) begin : g_inv
      assign snapshot[8*i +: 8] = ~{dots[i], segments[7*i +: 7]};
    end else begin : g_true
      assign snapshot[8*i +: 8] = {dots[i], segments[7*i +: 7]};
    end
  end

  // Next-state decode and state-derived serial outputs.
  always_comb begin
    state_next   = state;
    phase_end    = (div_cnt == DIV_LAST);
    busy         = (state != IDLE);
    done         = done_q;
    serial_clk   = (state == SHIFT_HI);
    serial_latch = (state == LATCH);
    serial_data  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT_LO;
      end
      SHIFT_LO: begin
        serial_data = shreg[NBITS-1];
        if (phase_end) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        serial_data = shreg[NBITS-1];
        if (phase_end) state_next = (bit_cnt == BIT_LAST) ? LATCH : SHIFT_LO;
      end
      LATCH: begin
        if (phase_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, snapshot shifter, bit counter and phase divider.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state == LATCH) && phase_end;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= snapshot;
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            div_cnt <= '0;
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_shift_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_shift_out
// Purpose  : Directed bench for seg7_shift_out: default, common-anode and
//            CLK_DIV=1/NUM_DIGITS=2 instances driven from one sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_shift_out;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults; instance 1: common anode; instance 2: fast/small.
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [41:0] seg0 = '0, seg1 = '0;
  logic [5:0]  dot0 = '0, dot1 = '0;
  logic [13:0] seg2 = '0;
  logic [1:0]  dot2 = '0;
  logic busy0, done0, sclk0, sdat0, slat0;
  logic busy1, done1, sclk1, sdat1, slat1;
  logic busy2, done2, sclk2, sdat2, slat2;

  seg7_shift_out dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .segments(seg0), .dots(dot0),
    .busy(busy0), .done(done0), .serial_clk(sclk0), .serial_data(sdat0),
    .serial_latch(slat0));

  seg7_shift_out #(.COMMON_ANODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .segments(seg1), .dots(dot1),
    .busy(busy1), .done(done1), .serial_clk(sclk1), .serial_data(sdat1),
    .serial_latch(slat1));

  seg7_shift_out #(.NUM_DIGITS(2), .CLK_DIV(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .segments(seg2), .dots(dot2),
    .busy(busy2), .done(done2), .serial_clk(sclk2), .serial_data(sdat2),
    .serial_latch(slat2));

  int   sel = 0;
  logic m_busy, m_done, m_clk, m_data, m_latch;

  // Route the selected instance onto the monitor signals.
  always_comb begin
    m_busy = busy0; m_done = done0; m_clk = sclk0; m_data = sdat0; m_latch = slat0;
    if (sel == 1) begin
      m_busy = busy1; m_done = done1; m_clk = sclk1; m_data = sdat1; m_latch = slat1;
    end else if (sel == 2) begin
      m_busy = busy2; m_done = done2; m_clk = sclk2; m_data = sdat2; m_latch = slat2;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Results of the most recent run_xfer.
  logic [63:0] cap;
  int nrise, first_rise, latch_first, latch_cnt, done_first, done_cnt;
  int viol, busy_low, busy_at1, busy_at_done;
  logic [4:0] after_rst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v;
    else if (sel == 1) start1 = v;
    else start2 = v;
  endtask

  // Start a transfer in cycle 0 (current negedge) and observe cycles 1..ncyc.
  task automatic run_xfer(input int ncyc, input bit hold, input int mid,
                          input int rst_rise, input int win);
    logic prev_clk, prev_data;
    bit   rst_pending;
    cap = '0; nrise = 0; first_rise = -1; latch_first = -1; latch_cnt = 0;
    done_first = -1; done_cnt = 0; viol = 0; busy_low = 0; busy_at1 = -1;
    busy_at_done = -1; after_rst = 5'h1f; rst_pending = 1'b0;
    prev_clk = m_clk; prev_data = m_data;
    set_start(1'b1);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (!hold && n == 1) set_start(1'b0);
      if (n == mid) begin set_start(1'b1); seg0 = ~seg0; end
      if (n == mid + 1) set_start(1'b0);
      if (rst_pending) begin
        after_rst = {m_clk, m_data, m_latch, m_busy, m_done};
        reset_n = 1'b1;
        rst_pending = 1'b0;
      end
      if (n == 1) busy_at1 = int'(m_busy);
      if (m_clk && !prev_clk) begin
        nrise++;
        cap = {cap[62:0], m_data};
        if (first_rise < 0) first_rise = n;
        if (nrise == rst_rise) begin reset_n = 1'b0; rst_pending = 1'b1; end
      end
      if (m_clk && (m_data !== prev_data)) viol++;
      if (m_latch) begin latch_cnt++; if (latch_first < 0) latch_first = n; end
      if (m_done) begin
        done_cnt++;
        if (done_first < 0) begin done_first = n; busy_at_done = int'(m_busy); end
      end
      if (!m_busy && n <= win) busy_low++;
      prev_clk = m_clk; prev_data = m_data;
    end
  endtask

  initial begin
    // Reset held 5 cycles with start asserted on every instance.
    start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("reset_outputs", {busy0, done0, sclk0, sdat0, slat0, busy1, done1, sclk1,
          sdat1, slat1, busy2, done2, sclk2, sdat2, slat2}, 64'h0);
    end
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy0, busy1, busy2}, 64'h0);

    // Default transfer: every digit shows "1", dp only on digit 0.
    sel = 0;
    seg0 = {6{7'b0110000}};
    dot0 = 6'b000001;
    run_xfer(395, 1'b0, -10, -1, 0);
    chk("def_rises", 64'(nrise), 64'd48);
    chk("def_bits", cap[47:0], 64'h303030_3030B0);
    chk("def_busy_c1", 64'(busy_at1), 64'd1);
    chk("def_first_rise", 64'(first_rise), 64'd5);
    chk("def_latch_first", 64'(latch_first), 64'd385);
    chk("def_latch_len", 64'(latch_cnt), 64'd4);
    chk("def_done_cycle", 64'(done_first), 64'd389);
    chk("def_done_count", 64'(done_cnt), 64'd1);
    chk("def_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("def_data_stable", 64'(viol), 64'd0);

    // Restart and flip inputs at cycle 100: snapshot must be unaffected.
    @(negedge clk);
    run_xfer(400, 1'b0, 100, -1, 0);
    seg0 = {6{7'b0110000}};
    chk("mid_bits", cap[47:0], 64'h303030_3030B0);
    chk("mid_done_count", 64'(done_cnt), 64'd1);
    chk("mid_done_cycle", 64'(done_first), 64'd389);

    // Reset at the 20th serial_clk rise: no latch, no done.
    @(negedge clk);
    run_xfer(400, 1'b0, -10, 20, 0);
    chk("rst_outputs", 64'(after_rst), 64'h0);
    chk("rst_no_latch", 64'(latch_cnt), 64'd0);
    chk("rst_no_done", 64'(done_cnt), 64'd0);
    chk("rst_rises", 64'(nrise), 64'd20);
    @(negedge clk);
    run_xfer(395, 1'b0, -10, -1, 0);
    chk("post_rst_bits", cap[47:0], 64'h303030_3030B0);
    chk("post_rst_done", 64'(done_first), 64'd389);

    // Common anode, all-zero inputs: every bit inverted to one.
    sel = 1;
    @(negedge clk);
    run_xfer(395, 1'b0, -10, -1, 0);
    chk("ca_rises", 64'(nrise), 64'd48);
    chk("ca_bits", cap[47:0], 64'hFFFF_FFFF_FFFF);
    chk("ca_latch_first", 64'(latch_first), 64'd385);
    chk("ca_latch_len", 64'(latch_cnt), 64'd4);
    chk("ca_done_cycle", 64'(done_first), 64'd389);

    // Start held high, CLK_DIV=1, two digits: back-to-back transfers.
    sel = 2;
    seg2 = {7'b1101101, 7'b0110011};
    dot2 = 2'b10;
    @(negedge clk);
    run_xfer(68, 1'b1, -10, -1, 67);
    chk("hold_rises", 64'(nrise), 64'd32);
    chk("hold_bits", cap[31:0], 64'hED33ED33);
    chk("hold_first_rise", 64'(first_rise), 64'd2);
    chk("hold_latch_first", 64'(latch_first), 64'd33);
    chk("hold_latch_count", 64'(latch_cnt), 64'd2);
    chk("hold_done_first", 64'(done_first), 64'd34);
    chk("hold_done_count", 64'(done_cnt), 64'd2);
    chk("hold_busy_gap", 64'(busy_low), 64'd1);
    chk("hold_data_stable", 64'(viol), 64'd0);
    start2 = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
